// File: rtl/lsu_pkg.sv
// Shared encodings and FSM state type for the LSU byte serializer.
package lsu_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_RESP
  } lsu_state_e;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input logic [1:0] sel);
    case (sel)
      MEM_B:   size_mask = 3'b000;
      MEM_H:   size_mask = 3'b001;
      MEM_W:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_serializer_if.sv
// Request/response channel between the MEM stage and the LSU byte serializer.
interface lsu_byte_serializer_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_sel;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_sel, req_sign, req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_sel, req_sign, req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load-result formatter: keeps the low 8<<sel bits of the
// assembled bytes and sign- or zero-fills the rest of the register.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] bytes_i,
  input  logic [1:0]      sel_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] data_o
);

  int   nbits;
  logic fill;

  always_comb begin
    nbits  = XLEN;
    fill   = 1'b0;
    data_o = '0;
    case (sel_i)
      MEM_B: begin
        nbits = 8;
        fill  = sign_i & bytes_i[7];
      end
      MEM_H: begin
        nbits = 16;
        fill  = sign_i & bytes_i[15];
      end
      MEM_W: begin
        nbits = 32;
        fill  = sign_i & bytes_i[31];
      end
      default: nbits = XLEN;
    endcase
    for (int i = 0; i < XLEN; i++) begin
      data_o[i] = (i < nbits) ? bytes_i[i] : fill;
    end
  end

endmodule

// File: rtl/lsu_byte_serializer.sv
// Byte-serial load/store engine for the byte-wide HCI bus.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of running byte-wise.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | ready for a request, bus held at zero
//  ST_STORE | one write beat per cycle, N beats
//  ST_LOAD  | issuing read addresses while collecting bytes RD_LAT later
//  ST_RESP  | one-cycle completion pulse
module lsu_byte_serializer
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  lsu_byte_serializer_if.slave lsu,
  input  logic                flush,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [7:0]          mem_wdata_o,
  input  logic [7:0]          mem_rdata_i
);

  localparam int CW = $clog2(XLEN / 8);
  localparam int NW = CW + 1;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT out of range");
  end

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [1:0]        sel_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [NW-1:0]     n_q;
  logic [NW-1:0]     iss_q;
  logic [CW-1:0]     cap_q;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT:0]   vld_shift;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   resp_rdata_q;
  logic [4:0]        resp_rd_q;
  logic              resp_err_q;

  logic [1:0]        sel_eff;
  logic [NW-1:0]     n_req;
  logic              accept, misalign;
  logic              issue, iss_load, iss_last;
  logic              capture, cap_last;
  logic [XLEN-1:0]   ext_data;

  // Doubleword has no meaning on a 32-bit core; it degrades to a word access.
  assign sel_eff = (XLEN == 32 && lsu.req_sel == MEM_D) ? MEM_W : lsu.req_sel;
  assign n_req   = NW'(1) << sel_eff;
  assign accept  = (state_q == ST_IDLE) && lsu.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = |(lsu.req_addr[2:0] & size_mask(sel_eff));
`else
  assign misalign = 1'b0;
`endif

  assign iss_load = (state_q == ST_LOAD) && (iss_q != n_q);
  assign issue    = (state_q == ST_STORE) || iss_load;
  assign iss_last = (iss_q == n_q - NW'(1));
  assign capture  = (state_q == ST_LOAD) && vld_q[RD_LAT-1];
  assign cap_last = capture && ({1'b0, cap_q} == n_q - NW'(1));

  assign vld_shift = {vld_q, iss_load};
  assign vld_d     = vld_shift[RD_LAT-1:0];

  always_comb begin
    buf_d = buf_q;
    if (capture) buf_d[{cap_q, 3'b000} +: 8] = mem_rdata_i;
  end

  // Extend from the next buffer value so the last byte lands in the response directly.
  lsu_load_extend #(.XLEN(XLEN)) u_extend (
    .bytes_i (buf_d),
    .sel_i   (sel_q),
    .sign_i  (sign_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu.req_valid) begin
          if (misalign)        state_d = ST_RESP;
          else if (lsu.req_we) state_d = ST_STORE;
          else                 state_d = ST_LOAD;
        end
      end
      ST_STORE: if (iss_last) state_d = ST_RESP;
      ST_LOAD: begin
        if (flush)         state_d = ST_IDLE;
        else if (cap_last) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      sel_q        <= MEM_B;
      sign_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      n_q          <= '0;
      iss_q        <= '0;
      cap_q        <= '0;
      vld_q        <= '0;
      buf_q        <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Leaving LOAD for any reason drops whatever reads are still in flight.
      vld_q   <= (state_q == ST_LOAD && !flush) ? vld_d : '0;
      if (accept) begin
        we_q    <= lsu.req_we;
        sel_q   <= sel_eff;
        sign_q  <= lsu.req_sign;
        addr_q  <= lsu.req_addr;
        wdata_q <= lsu.req_wdata;
        rd_q    <= lsu.req_rd;
        n_q     <= n_req;
        iss_q   <= '0;
        cap_q   <= '0;
        buf_q   <= '0;
      end else begin
        if (issue)   iss_q <= iss_q + NW'(1);
        if (capture) cap_q <= cap_q + CW'(1);
        buf_q <= buf_d;
      end
      if (accept && misalign) begin
        resp_rd_q    <= lsu.req_rd;
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b1;
      end else if (state_q != ST_RESP && state_d == ST_RESP) begin
        resp_rd_q    <= rd_q;
        resp_rdata_q <= we_q ? '0 : ext_data;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign lsu.req_ready  = (state_q == ST_IDLE);
  assign lsu.resp_valid = (state_q == ST_RESP);
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_rd    = resp_rd_q;
  assign lsu.resp_err   = resp_err_q;
  assign busy           = (state_q != ST_IDLE);

  assign mem_addr_o  = issue ? addr_q + ADDR_W'(iss_q) : '0;
  assign mem_we_o    = (state_q == ST_STORE);
  assign mem_wdata_o = (state_q == ST_STORE) ? wdata_q[{iss_q[CW-1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_lsu_byte_serializer.sv
// Self-checking bench for lsu_byte_serializer: vector table plus scoreboard,
// with hand sequences for flush, mid-access reset and pulse/ready timing.
module tb_lsu_byte_serializer;
  import lsu_pkg::*;

  localparam int XLEN      = 32;
  localparam int ADDR_W    = 32;
  localparam int TB_RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;

  always #5 clk = ~clk;

  lsu_byte_serializer_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) lsu_if ();

  lsu_byte_serializer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_LAT(TB_RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu         (lsu_if),
    .flush       (flush),
    .busy        (busy),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Byte memory with a fixed read latency, aliased on the low 12 address bits.
  logic [7:0]  mem [4096];
  logic [11:0] rd_pipe [TB_RD_LAT];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_we_o) begin
      mem[mem_addr_o[11:0]] <= mem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
    rd_pipe[0] <= mem_addr_o[11:0];
    for (int i = 1; i < TB_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = mem[rd_pipe[TB_RD_LAT-1]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && lsu_if.resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid required=no response (rd=%0d)", lsu_if.resp_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", lsu_if.resp_rdata, e.data);
        chk("resp_rd", lsu_if.resp_rd, e.rd);
        chk("resp_err", lsu_if.resp_err, e.err);
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic drive_req(input vec_t v, input logic fl);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_we    = v.we;
    lsu_if.req_sel   = v.sel;
    lsu_if.req_sign  = v.sign;
    lsu_if.req_addr  = v.addr;
    lsu_if.req_wdata = v.wdata;
    lsu_if.req_rd    = v.rd;
    flush            = fl;
  endtask

  task automatic do_req(input string tag, input vec_t v, input logic fl);
    int          n, lat, resp_c;
    logic        mis, got, iss, ewe;
    logic [31:0] ea, wd;
    logic [7:0]  ewd;
    exp_t        e;
    n   = (v.sel == MEM_D) ? 4 : (1 << v.sel);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (v.addr & (n - 1)) != 0;
`else
    mis = 1'b0;
`endif
    lat = mis ? 1 : (v.we ? n + 1 : n + TB_RD_LAT + 1);
    wd  = v.wdata;
    @(negedge clk);
    chk({tag, "_ready_idle"}, lsu_if.req_ready, 1'b1);
    drive_req(v, fl);
    e.rd   = v.rd;
    e.data = mis ? 32'h0 : v.exp;
    e.err  = mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    lsu_if.req_valid = 1'b0;
    flush = 1'b0;
    got = 1'b0;
    resp_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!got) begin
        iss = !mis && (c <= n);
        ea  = iss ? v.addr + 32'(c - 1) : 32'h0;
        ewe = iss && v.we;
        ewd = ewe ? wd[8*(c-1) +: 8] : 8'h00;
        chk({tag, "_bus"}, {mem_addr_o, mem_we_o, mem_wdata_o}, {ea, ewe, ewd});
        if (lsu_if.resp_valid) begin
          chk({tag, "_latency"}, c, lat);
          got = 1'b1;
          resp_c = c;
        end else begin
          chk({tag, "_ready_busy"}, {lsu_if.req_ready, busy}, 2'b01);
        end
      end else if (c == resp_c + 1) begin
        chk({tag, "_pulse_ready"}, {lsu_if.resp_valid, lsu_if.req_ready, busy}, 3'b010);
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no resp_valid in 20 cycles required=resp in cycle %0d", tag, lat);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wr0;
    vec_t v;

    //           we    sel    sign  addr          wdata         rd      exp
    vecs[0]  = '{1'b1, MEM_W, 1'b0, 32'h00000100, 32'hDEADBEEF, 5'd1,  32'h00000000};
    vecs[1]  = '{1'b0, MEM_W, 1'b0, 32'h00000100, 32'h0,        5'd2,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, MEM_B, 1'b1, 32'h00000100, 32'h0,        5'd3,  32'hFFFFFFEF};
    vecs[3]  = '{1'b0, MEM_B, 1'b0, 32'h00000101, 32'h0,        5'd4,  32'h000000BE};
    vecs[4]  = '{1'b0, MEM_H, 1'b1, 32'h00000102, 32'h0,        5'd5,  32'hFFFFDEAD};
    vecs[5]  = '{1'b0, MEM_H, 1'b0, 32'h00000102, 32'h0,        5'd6,  32'h0000DEAD};
    vecs[6]  = '{1'b1, MEM_B, 1'b0, 32'h00000010, 32'hFFFFFF80, 5'd7,  32'h00000000};
    vecs[7]  = '{1'b0, MEM_B, 1'b1, 32'h00000010, 32'h0,        5'd8,  32'hFFFFFF80};
    vecs[8]  = '{1'b0, MEM_B, 1'b0, 32'h00000010, 32'h0,        5'd9,  32'h00000080};
    vecs[9]  = '{1'b1, MEM_H, 1'b0, 32'h00000030, 32'h00008001, 5'd10, 32'h00000000};
    vecs[10] = '{1'b0, MEM_H, 1'b1, 32'h00000030, 32'h0,        5'd11, 32'hFFFF8001};
    vecs[11] = '{1'b1, MEM_D, 1'b0, 32'h00000040, 32'h11223344, 5'd12, 32'h00000000};
    vecs[12] = '{1'b0, MEM_D, 1'b1, 32'h00000040, 32'h0,        5'd13, 32'h11223344};
    vecs[13] = '{1'b1, MEM_W, 1'b0, 32'h00000104, 32'h55667788, 5'd14, 32'h00000000};
    vecs[14] = '{1'b0, MEM_W, 1'b0, 32'h00000102, 32'h0,        5'd15, 32'h7788DEAD};
    vecs[15] = '{1'b1, MEM_B, 1'b0, 32'hFFFFFFFF, 32'h0000005A, 5'd16, 32'h00000000};
    vecs[16] = '{1'b1, MEM_B, 1'b0, 32'h00000000, 32'h000000A5, 5'd17, 32'h00000000};
    vecs[17] = '{1'b0, MEM_H, 1'b0, 32'hFFFFFFFF, 32'h0,        5'd18, 32'h0000A55A};
    vecs[18] = '{1'b0, MEM_W, 1'b1, 32'h00000100, 32'h0,        5'd19, 32'hDEADBEEF};

    lsu_if.req_valid = 1'b0;
    lsu_if.req_we    = 1'b0;
    lsu_if.req_sel   = MEM_B;
    lsu_if.req_sign  = 1'b0;
    lsu_if.req_addr  = '0;
    lsu_if.req_wdata = '0;
    lsu_if.req_rd    = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_busy", {lsu_if.req_ready, busy, lsu_if.resp_valid}, 3'b100);
    chk("reset_bus", {mem_addr_o, mem_we_o, mem_wdata_o}, 41'h0);
    chk("reset_resp", {lsu_if.resp_rdata, lsu_if.resp_rd, lsu_if.resp_err}, 38'h0);

    for (int i = 0; i < NVEC; i++) do_req($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Flush during the second cycle of a word load: no response, idle next cycle.
    v = '{1'b0, MEM_W, 1'b0, 32'h00000100, 32'h0, 5'd20, 32'h0};
    @(negedge clk);
    drive_req(v, 1'b0);
    @(posedge clk);
    #1 lsu_if.req_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_c3", {lsu_if.req_ready, busy}, 2'b10);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush_no_resp", {lsu_if.resp_valid, mem_addr_o, mem_we_o}, 34'h0);
    end
    do_req("post_flush_st", '{1'b1, MEM_W, 1'b0, 32'h00000200, 32'h0BADF00D, 5'd21, 32'h0}, 1'b0);
    do_req("post_flush_ld", '{1'b0, MEM_W, 1'b0, 32'h00000200, 32'h0, 5'd22, 32'h0BADF00D}, 1'b0);
    // Flush together with an idle request must not block acceptance.
    do_req("flush_accept", '{1'b0, MEM_B, 1'b0, 32'h00000010, 32'h0, 5'd23, 32'h00000080}, 1'b1);

    // Synchronous reset in cycle 2 of a word store: two bytes written, all quiet after.
    wr0 = wr_cnt;
    v = '{1'b1, MEM_W, 1'b0, 32'h00000300, 32'h11223344, 5'd24, 32'h0};
    @(negedge clk);
    drive_req(v, 1'b0);
    @(posedge clk);
    #1 lsu_if.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus", {mem_addr_o, mem_we_o, mem_wdata_o}, 41'h0);
    chk("rst_mid_resp", {lsu_if.resp_valid, lsu_if.resp_rdata, lsu_if.resp_rd, lsu_if.resp_err}, 39'h0);
    chk("rst_mid_ready", {lsu_if.req_ready, busy}, 2'b10);
    repeat (6) @(negedge clk);
    chk("rst_mid_writes", 64'(wr_cnt - wr0), 64'd2);
    chk("rst_mid_bytes", {mem[12'h300], mem[12'h301]}, 16'h4433);
    do_req("post_rst_ld", vecs[1], 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
